// File: rtl/lock_pkg.sv
// Shared definitions for the access sequencer.
//   - timer width used by the tick timer and the lockout countdown
//   - externally visible mode encodings
//   - controller state enumeration and the state -> mode mapping
package lock_pkg;

  localparam int TIMER_W = 12;

  localparam logic [1:0] MODE_NORMAL = 2'd0;
  localparam logic [1:0] MODE_SET    = 2'd1;
  localparam logic [1:0] MODE_OPEN   = 2'd2;
  localparam logic [1:0] MODE_LOCKED = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SET_AUTH,
    ST_SET_NEW,
    ST_OPEN,
    ST_LOCKOUT
  } state_e;

  function automatic logic [1:0] state_mode(input state_e s);
    logic [1:0] m;
    case (s)
      ST_SET_AUTH, ST_SET_NEW: m = MODE_SET;
      ST_OPEN:                 m = MODE_OPEN;
      ST_LOCKOUT:              m = MODE_LOCKED;
      default:                 m = MODE_NORMAL;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/tick_timer.sv
// Prescaled down-counter.
//   clk, rst_n  : system clock, async active-low reset
//   load        : restart; clears the prescaler and loads load_value
//   load_value  : count to load, in ticks
//   value       : current count
//   tick        : high on the cycle whose clock edge ends a TICK_DIV period
//   expire      : tick on which the count goes from 1 to 0
module tick_timer
  import lock_pkg::*;
#(
  parameter int TICK_DIV = 1000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_value,
  output logic [TIMER_W-1:0] value,
  output logic               tick,
  output logic               expire
);

  localparam int PW = $clog2(TICK_DIV);

  logic [PW-1:0]      presc_q;
  logic [TIMER_W-1:0] count_q;

  // The prescaler restarts from 0 on load, so the first tick lands
  // exactly TICK_DIV edges after the load edge.
  assign tick   = (presc_q == PW'(TICK_DIV - 1));
  assign expire = tick && (count_q == TIMER_W'(1));
  assign value  = count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      count_q <= '0;
    end else if (load) begin
      presc_q <= '0;
      count_q <= load_value;
    end else begin
      presc_q <= tick ? '0 : presc_q + PW'(1);
      if (tick && (count_q != '0)) begin
        count_q <= count_q - TIMER_W'(1);
      end
    end
  end

endmodule

// File: rtl/access_sequencer.sv
// Door-lock access sequencer.
//   clk, rst_n      : system clock, async active-low reset
//   enter_req       : pulse, four-digit entry complete (match sampled with it)
//   match           : comparator result
//   set_req         : password-setting switch level (rising edge used)
//   cancel          : pulse, abandon current operation
//   mode            : 0 normal, 1 setting, 2 open, 3 locked
//   commit_pw       : pulse, write the new password
//   entry_clr       : pulse, clear entered digits and cursor
//   fail_cnt        : consecutive failures (saturates at 7)
//   lock_remaining  : lockout ticks left, 0 outside lockout
//   servo_en        : door servo open command
//   alarm_en        : piezo enable
//
// state      | meaning
// IDLE       | waiting for a code entry or the set switch
// SET_AUTH   | setting requested, waiting for the current code
// SET_NEW    | authenticated, next entry becomes the new code
// OPEN       | door open for OPEN_TICKS
// LOCKOUT    | too many failures, all inputs ignored until expiry
module access_sequencer
  import lock_pkg::*;
#(
  parameter int TICK_DIV        = 1000,
  parameter int OPEN_TICKS      = 200,
  parameter int MAX_FAIL        = 3,
  parameter int LOCK_BASE_TICKS = 100
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enter_req,
  input  logic               match,
  input  logic               set_req,
  input  logic               cancel,
  output logic [1:0]         mode,
  output logic               commit_pw,
  output logic               entry_clr,
  output logic [2:0]         fail_cnt,
  output logic [TIMER_W-1:0] lock_remaining,
  output logic               servo_en,
  output logic               alarm_en
);

  localparam logic [2:0] MAX_FAIL_L = 3'(MAX_FAIL);

  state_e             state_q, state_d;
  logic [2:0]         fail_q, fail_d, fail_inc;
  logic [1:0]         lvl_q, lvl_d;
  logic               set_q;
  logic               set_rise;
  logic               commit_q, commit_d;
  logic               clr_q, clr_d;
  logic [1:0]         mode_q;
  logic               servo_q, alarm_q;
  logic [TIMER_W-1:0] lock_rem_q, lock_rem_d;

  logic               tmr_load;
  logic [TIMER_W-1:0] tmr_load_val;
  logic [TIMER_W-1:0] tmr_value;
  logic               tmr_tick;
  logic               tmr_expire;
  logic [TIMER_W-1:0] lock_dur;

  tick_timer #(
    .TICK_DIV (TICK_DIV)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (tmr_load),
    .load_value (tmr_load_val),
    .value      (tmr_value),
    .tick       (tmr_tick),
    .expire     (tmr_expire)
  );

  assign set_rise = set_req & ~set_q;
  assign fail_inc = (fail_q == 3'd7) ? 3'd7 : fail_q + 3'd1;
  // Duration uses the level before this lockout bumps it.
  assign lock_dur = TIMER_W'(LOCK_BASE_TICKS) << lvl_q;

  always_comb begin
    state_d  = state_q;
    fail_d   = fail_q;
    lvl_d    = lvl_q;
    commit_d = 1'b0;
    clr_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cancel) begin
          clr_d = 1'b1;
        end else if (enter_req) begin
          clr_d = 1'b1;
          if (match) begin
            state_d = ST_OPEN;
            fail_d  = 3'd0;
            lvl_d   = 2'd0;
          end else begin
            fail_d = fail_inc;
            if (fail_inc >= MAX_FAIL_L) begin
              state_d = ST_LOCKOUT;
              lvl_d   = (lvl_q == 2'd3) ? 2'd3 : lvl_q + 2'd1;
            end
          end
        end else if (set_rise) begin
          state_d = ST_SET_AUTH;
        end
      end

      ST_SET_AUTH: begin
        if (cancel) begin
          state_d = ST_IDLE;
          clr_d   = 1'b1;
        end else if (enter_req) begin
          clr_d = 1'b1;
          if (match) begin
            state_d = ST_SET_NEW;
          end else begin
            fail_d = fail_inc;
            if (fail_inc >= MAX_FAIL_L) begin
              state_d = ST_LOCKOUT;
              lvl_d   = (lvl_q == 2'd3) ? 2'd3 : lvl_q + 2'd1;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
      end

      ST_SET_NEW: begin
        if (cancel) begin
          state_d = ST_IDLE;
          clr_d   = 1'b1;
        end else if (enter_req) begin
          state_d  = ST_IDLE;
          commit_d = 1'b1;
          clr_d    = 1'b1;
        end
      end

      ST_OPEN: begin
        if (tmr_expire) begin
          state_d = ST_IDLE;
        end else if (cancel) begin
          state_d = ST_IDLE;
          clr_d   = 1'b1;
        end
      end

      ST_LOCKOUT: begin
        if (tmr_expire) begin
          state_d = ST_IDLE;
          fail_d  = 3'd0;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (state_d != state_q) begin
      clr_d = 1'b1;
    end
  end

  assign tmr_load = (state_d != state_q);

  always_comb begin
    case (state_d)
      ST_OPEN:    tmr_load_val = TIMER_W'(OPEN_TICKS);
      ST_LOCKOUT: tmr_load_val = lock_dur;
      default:    tmr_load_val = '0;
    endcase
  end

  // Mirror the timer's next count so lock_remaining stays registered yet
  // tracks the timer cycle-for-cycle.
  always_comb begin
    lock_rem_d = '0;
    if (state_d == ST_LOCKOUT) begin
      if (tmr_load)      lock_rem_d = tmr_load_val;
      else if (tmr_tick) lock_rem_d = tmr_value - TIMER_W'(1);
      else               lock_rem_d = tmr_value;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      fail_q     <= 3'd0;
      lvl_q      <= 2'd0;
      set_q      <= 1'b0;
      commit_q   <= 1'b0;
      clr_q      <= 1'b0;
      mode_q     <= MODE_NORMAL;
      servo_q    <= 1'b0;
      alarm_q    <= 1'b0;
      lock_rem_q <= '0;
    end else begin
      state_q    <= state_d;
      fail_q     <= fail_d;
      lvl_q      <= lvl_d;
      set_q      <= set_req;
      commit_q   <= commit_d;
      clr_q      <= clr_d;
      mode_q     <= state_mode(state_d);
      servo_q    <= (state_d == ST_OPEN);
      alarm_q    <= (state_d == ST_LOCKOUT);
      lock_rem_q <= lock_rem_d;
    end
  end

  assign mode           = mode_q;
  assign commit_pw      = commit_q;
  assign entry_clr      = clr_q;
  assign fail_cnt       = fail_q;
  assign lock_remaining = lock_rem_q;
  assign servo_en       = servo_q;
  assign alarm_en       = alarm_q;

endmodule

// File: tb/tb_access_sequencer.sv
module tb_access_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enter_req, match, set_req, cancel;
  logic [1:0]  mode;
  logic        commit_pw, entry_clr, servo_en, alarm_en;
  logic [2:0]  fail_cnt;
  logic [11:0] lock_remaining;

  int errors = 0;
  int checks = 0;

  access_sequencer #(
    .TICK_DIV        (4),
    .OPEN_TICKS      (5),
    .MAX_FAIL        (3),
    .LOCK_BASE_TICKS (2)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .enter_req      (enter_req),
    .match          (match),
    .set_req        (set_req),
    .cancel         (cancel),
    .mode           (mode),
    .commit_pw      (commit_pw),
    .entry_clr      (entry_clr),
    .fail_cnt       (fail_cnt),
    .lock_remaining (lock_remaining),
    .servo_en       (servo_en),
    .alarm_en       (alarm_en)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_enter(input logic m);
    enter_req = 1'b1;
    match     = m;
    step();
    enter_req = 1'b0;
    match     = 1'b0;
  endtask

  task automatic pulse_cancel();
    cancel = 1'b1;
    step();
    cancel = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if (mode !== 2'd0 || fail_cnt !== 3'd0 || lock_remaining !== 12'd0) begin
      errors++;
      $display("FAIL reset_state: mode=%0d fail=%0d rem=%0d want 0 0 0", mode, fail_cnt, lock_remaining);
    end
    checks++;
    if ({commit_pw, entry_clr, servo_en, alarm_en} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_pulses: commit/clr/servo/alarm=%b want 0000", {commit_pw, entry_clr, servo_en, alarm_en});
    end
    step();
    rst_n = 1'b1;
    step();
    checks++;
    if (mode !== 2'd0 || entry_clr !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: mode=%0d clr=%0d want 0 0", mode, entry_clr);
    end
  endtask

  task automatic test_open();
    int n;
    pulse_enter(1'b1);
    checks++;
    if (mode !== 2'd2 || servo_en !== 1'b1 || entry_clr !== 1'b1) begin
      errors++;
      $display("FAIL open_entry: mode=%0d servo=%0d clr=%0d want 2 1 1", mode, servo_en, entry_clr);
    end
    n = 0;
    while (mode == 2'd2 && n < 100) begin
      step();
      n++;
    end
    checks++;
    if (n !== 20) begin
      errors++;
      $display("FAIL open_duration: cycles=%0d want 20", n);
    end
    checks++;
    if (mode !== 2'd0 || servo_en !== 1'b0 || entry_clr !== 1'b1) begin
      errors++;
      $display("FAIL open_expire: mode=%0d servo=%0d clr=%0d want 0 0 1", mode, servo_en, entry_clr);
    end
  endtask

  task automatic test_lockout_escalation();
    logic [11:0] exp_rem [5];
    int n;
    exp_rem = '{12'd2, 12'd4, 12'd8, 12'd16, 12'd16};
    for (int r = 0; r < 5; r++) begin
      pulse_enter(1'b0);
      pulse_enter(1'b0);
      checks++;
      if (fail_cnt !== 3'd2 || mode !== 2'd0) begin
        errors++;
        $display("FAIL lock_pre[%0d]: fail=%0d mode=%0d want 2 0", r, fail_cnt, mode);
      end
      pulse_enter(1'b0);
      checks++;
      if (mode !== 2'd3 || fail_cnt !== 3'd3 || lock_remaining !== exp_rem[r] || alarm_en !== 1'b1) begin
        errors++;
        $display("FAIL lock_entry[%0d]: mode=%0d fail=%0d rem=%0d alarm=%0d want 3 3 %0d 1",
                 r, mode, fail_cnt, lock_remaining, alarm_en, exp_rem[r]);
      end
      n = 0;
      while (mode == 2'd3 && n < 200) begin
        step();
        n++;
      end
      checks++;
      if (n !== 4 * int'(exp_rem[r]) || fail_cnt !== 3'd0 || alarm_en !== 1'b0) begin
        errors++;
        $display("FAIL lock_exit[%0d]: cycles=%0d fail=%0d alarm=%0d want %0d 0 0",
                 r, n, fail_cnt, alarm_en, 4 * int'(exp_rem[r]));
      end
    end
  endtask

  task automatic test_reset_mid_lockout();
    for (int i = 0; i < 3; i++) pulse_enter(1'b0);
    checks++;
    if (lock_remaining !== 12'd16) begin
      errors++;
      $display("FAIL rst_lock_pre: rem=%0d want 16", lock_remaining);
    end
    step(); step(); step();
    rst_n = 1'b0;
    #1;
    checks++;
    if (mode !== 2'd0 || alarm_en !== 1'b0 || lock_remaining !== 12'd0 || commit_pw !== 1'b0) begin
      errors++;
      $display("FAIL rst_lock_abort: mode=%0d alarm=%0d rem=%0d commit=%0d want 0 0 0 0",
               mode, alarm_en, lock_remaining, commit_pw);
    end
    #3;
    rst_n = 1'b1;
    step();
    for (int i = 0; i < 3; i++) pulse_enter(1'b0);
    checks++;
    if (mode !== 2'd3 || lock_remaining !== 12'd2) begin
      errors++;
      $display("FAIL rst_lock_level: mode=%0d rem=%0d want 3 2", mode, lock_remaining);
    end
  endtask

  task automatic test_cancel_in_lockout();
    int n;
    pulse_cancel();
    checks++;
    if (mode !== 2'd3 || entry_clr !== 1'b0 || lock_remaining !== 12'd2) begin
      errors++;
      $display("FAIL lock_cancel: mode=%0d clr=%0d rem=%0d want 3 0 2", mode, entry_clr, lock_remaining);
    end
    step(); step(); step();
    checks++;
    if (lock_remaining !== 12'd1 || mode !== 2'd3) begin
      errors++;
      $display("FAIL lock_countdown: rem=%0d mode=%0d want 1 3", lock_remaining, mode);
    end
    n = 0;
    while (mode == 2'd3 && n < 100) begin
      step();
      n++;
    end
    checks++;
    if (n !== 4 || lock_remaining !== 12'd0) begin
      errors++;
      $display("FAIL lock_cancel_exit: cycles=%0d rem=%0d want 4 0", n, lock_remaining);
    end
  endtask

  task automatic test_set_flow();
    set_req = 1'b1;
    step();
    checks++;
    if (mode !== 2'd1 || entry_clr !== 1'b1) begin
      errors++;
      $display("FAIL set_auth: mode=%0d clr=%0d want 1 1", mode, entry_clr);
    end
    pulse_enter(1'b1);
    checks++;
    if (mode !== 2'd1 || commit_pw !== 1'b0) begin
      errors++;
      $display("FAIL set_new: mode=%0d commit=%0d want 1 0", mode, commit_pw);
    end
    pulse_enter(1'b0);
    checks++;
    if (commit_pw !== 1'b1 || mode !== 2'd0) begin
      errors++;
      $display("FAIL set_commit: commit=%0d mode=%0d want 1 0", commit_pw, mode);
    end
    step(); step(); step();
    checks++;
    if (commit_pw !== 1'b0 || mode !== 2'd0) begin
      errors++;
      $display("FAIL set_held_level: commit=%0d mode=%0d want 0 0", commit_pw, mode);
    end
    set_req = 1'b0;
    step();
    set_req = 1'b1;
    step();
    pulse_enter(1'b1);
    pulse_cancel();
    checks++;
    if (mode !== 2'd0 || commit_pw !== 1'b0 || entry_clr !== 1'b1) begin
      errors++;
      $display("FAIL set_cancel: mode=%0d commit=%0d clr=%0d want 0 0 1", mode, commit_pw, entry_clr);
    end
    set_req = 1'b0;
    step();
    set_req = 1'b1;
    step();
    pulse_enter(1'b0);
    checks++;
    if (mode !== 2'd0 || fail_cnt !== 3'd1) begin
      errors++;
      $display("FAIL set_auth_fail: mode=%0d fail=%0d want 0 1", mode, fail_cnt);
    end
    set_req = 1'b0;
    step();
  endtask

  task automatic test_cancel_priority();
    cancel    = 1'b1;
    enter_req = 1'b1;
    match     = 1'b1;
    step();
    cancel    = 1'b0;
    enter_req = 1'b0;
    match     = 1'b0;
    checks++;
    if (mode !== 2'd0 || servo_en !== 1'b0 || entry_clr !== 1'b1 || fail_cnt !== 3'd1) begin
      errors++;
      $display("FAIL cancel_prio: mode=%0d servo=%0d clr=%0d fail=%0d want 0 0 1 1",
               mode, servo_en, entry_clr, fail_cnt);
    end
    step();
    checks++;
    if (entry_clr !== 1'b0 || mode !== 2'd0) begin
      errors++;
      $display("FAIL cancel_prio_after: clr=%0d mode=%0d want 0 0", entry_clr, mode);
    end
  endtask

  task automatic test_open_cancel();
    pulse_enter(1'b1);
    checks++;
    if (mode !== 2'd2 || fail_cnt !== 3'd0) begin
      errors++;
      $display("FAIL open2_entry: mode=%0d fail=%0d want 2 0", mode, fail_cnt);
    end
    step();
    pulse_enter(1'b1);
    checks++;
    if (mode !== 2'd2 || entry_clr !== 1'b0) begin
      errors++;
      $display("FAIL open_ignore_enter: mode=%0d clr=%0d want 2 0", mode, entry_clr);
    end
    pulse_cancel();
    checks++;
    if (mode !== 2'd0 || servo_en !== 1'b0 || entry_clr !== 1'b1) begin
      errors++;
      $display("FAIL open_cancel: mode=%0d servo=%0d clr=%0d want 0 0 1", mode, servo_en, entry_clr);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    enter_req = 1'b0;
    match     = 1'b0;
    set_req   = 1'b0;
    cancel    = 1'b0;
    test_reset();
    test_open();
    test_lockout_escalation();
    test_reset_mid_lockout();
    test_cancel_in_lockout();
    test_set_flow();
    test_cancel_priority();
    test_open_cancel();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
